regfile_2r1w_32x32_ctl: RTL
===========================

# regfile_2r1w_32x32_ctl

Synchronous front-end controller for the 32x32 two-read/one-write register file macro. It accepts binary-addressed read and write requests, registers them, and drives the macro's predecoded one-hot address groups and write data. It captures macro read data into output registers with a valid strobe. After every reset it runs a clear sequence that writes zero to all 32 entries. It sits directly upstream of the macro and is the only block that drives its address and data pins.

## Interface
- No parameters.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ready  out  1  high when requests are accepted (RUN state).
- rd0_req, rd1_req  in  1  read request, port 0/1.
- rd0_adr_i, rd1_adr_i  in  [0:4]  read address (bit 0 = MSB).
- wr0_req  in  1  write request.
- wr0_adr_i  in  [0:4]  write address.
- wr0_dat_i  in  [0:31]  write data.
- rd0_vld, rd1_vld  out  1  read data valid strobe, one cycle per accepted read.
- rd0_dat_o, rd1_dat_o  out  [0:31]  captured read data.
- Macro side, per port p in {rd0, rd1, wr0}: p_c_na0, p_c_a0, p_na1_na2, p_na1_a2, p_a1_na2, p_a1_a2, p_na3, p_a3, p_na4, p_a4  out  1 each  predecoded address.
- wr0_dat  out  [0:31]  write data to macro.
- rd0_dat, rd1_dat  in  [0:31]  macro read data.

## Operation
- States: INIT, RUN. `rst`=1 forces INIT, clear counter `cnt`=0, and all registered outputs to 0.
- INIT:
  - Each cycle, drive a write of address `cnt` with data 0, then increment `cnt`.
  - After the write of address 31 is loaded, go to RUN.
  - `ready`=0. All requests are ignored, and no read is issued.
- RUN: `ready`=1. A request is accepted when its `*_req`=1 on a clock edge in RUN. No backpressure.
- Stage A (array drive) registers, loaded on the accept edge. For each port, the registers hold:
  - Enable group: `c_a0`=en&a0 and `c_na0`=en&~a0. Both are 0 when the port is idle.
  - a1/a2 group: exactly one of the four signals is high when enabled; all four are 0 when idle.
  - a3 group and a4 group: when enabled, exactly one of `na`/`a` is high; both are 0 when idle.
  - `wr0_dat` holds the write data. It keeps its last value while idle.
- Stage B (capture): on the edge after stage A, for each read port enabled in stage A:
  - `rdN_dat_o` is loaded from the macro's `rdN_dat`.
  - `rdN_vld`=1 for exactly one cycle.
  - `rdN_dat_o` holds its value while `rdN_vld`=0.
- Idle ports drive all-zero predecode, so the macro sees enable=0.
- Both reads may target the same address, or any address, in the same cycle, independently.

## Timing
- Read latency: a request accepted at edge E drives the macro after E and is captured at E+1. `rdN_vld`/`rdN_dat_o` are valid in the cycle after E+1 (2 cycles from request to data).
- Write: written by the macro during the cycle after the accept edge. A read accepted at least one cycle after a write's accept edge returns the new data.
- Same-cycle read and write to the same address: see Configuration.
- Reset: `ready` rises exactly 32 cycles after the first edge with `rst`=0. Reset asserted mid-operation, on the next edge:
  - pending stage A/B activity is discarded;
  - `rdN_vld`=0;
  - the clear sequence restarts from address 0.
- Macro write enable is only ever asserted from registered outputs; there are no combinational paths from request inputs to macro pins.

## Configuration
- `REGFILE_CTL_BYPASS_EN` defined: stage A compares each enabled read address with the enabled write address.
  - On a match, stage B captures the registered write data instead of the macro output.
  - A read accepted on the same edge as a write to the same address returns the new data.
- `REGFILE_CTL_BYPASS_EN` undefined: no comparator. Read data always comes from the macro, and the result of a same-cycle same-address collision is unspecified; benches must not check it.

## Test plan
- Reset release, then read all 32 addresses on both ports: `ready` is low for 32 cycles, and every read returns 0x00000000 with `vld` 2 cycles after the request.
- Write 0xDEADBEEF to address 5, then read port 0 at address 5 on the next cycle: `rd0_dat_o`=0xDEADBEEF, and the macro pins show `wr0_c_na0`=1, `wr0_na1_a2`=1, `wr0_na3`=1, `wr0_a4`=1.
- Read port 0 at address 31 and read port 1 at address 0 in the same cycle, after writing 0x1 and 0x2 there: `rd0_dat_o`=0x00000001 and `rd1_dat_o`=0x00000002 in the same cycle, each with `vld` high for one cycle.
- With bypass enabled: write 0xCAFEF00D and read address 9 on the same edge: the read returns 0xCAFEF00D.
- Assert `rst` for 1 cycle in the middle of back-to-back reads: no `vld` after the reset edge, and previously written address 3 reads 0 after `ready` returns.
- Hold requests high during INIT: they are ignored, no `vld` appears, and the clear writes addresses 0..31 in order.

Source files
------------

// File: rtl/regfile_2r1w_32x32_ctl_if.sv
// Request-side bus of the 32x32 2R1W register file controller.
// master = requester, slave = controller.
interface regfile_2r1w_32x32_ctl_if;
    logic        ready;
    logic        rd0_req;
    logic        rd1_req;
    logic [0:4]  rd0_adr_i;
    logic [0:4]  rd1_adr_i;
    logic        wr0_req;
    logic [0:4]  wr0_adr_i;
    logic [0:31] wr0_dat_i;
    logic        rd0_vld;
    logic        rd1_vld;
    logic [0:31] rd0_dat_o;
    logic [0:31] rd1_dat_o;

    modport master (
        input  ready, rd0_vld, rd1_vld, rd0_dat_o, rd1_dat_o,
        output rd0_req, rd1_req, rd0_adr_i, rd1_adr_i,
               wr0_req, wr0_adr_i, wr0_dat_i
    );

    modport slave (
        output ready, rd0_vld, rd1_vld, rd0_dat_o, rd1_dat_o,
        input  rd0_req, rd1_req, rd0_adr_i, rd1_adr_i,
               wr0_req, wr0_adr_i, wr0_dat_i
    );
endinterface

// File: rtl/regfile_2r1w_32x32_ctl.sv
// Front-end controller for the 32x32 2R1W register file macro: predecoded
// address drive, read capture, and a zero-clear after reset. Optional macro:
// REGFILE_CTL_BYPASS_EN (same-edge write-to-read forwarding).
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | clear sequence: write 0 to entry cnt each cycle, ready=0
// RUN   | requests accepted on every edge, ready=1
module regfile_2r1w_32x32_ctl (
    input  logic clk,
    input  logic rst,
    regfile_2r1w_32x32_ctl_if.slave bus,

    output logic rd0_c_na0, rd0_c_a0,
    output logic rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
    output logic rd0_na3, rd0_a3, rd0_na4, rd0_a4,

    output logic rd1_c_na0, rd1_c_a0,
    output logic rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
    output logic rd1_na3, rd1_a3, rd1_na4, rd1_a4,

    output logic wr0_c_na0, wr0_c_a0,
    output logic wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
    output logic wr0_na3, wr0_a3, wr0_na4, wr0_a4,

    output logic [0:31] wr0_dat,
    input  logic [0:31] rd0_dat,
    input  logic [0:31] rd1_dat
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [0:4]  cnt;
    logic        ready_q;

    // Stage A: predecode groups {c_na0,c_a0,na1_na2,na1_a2,a1_na2,a1_a2,na3,a3,na4,a4}
    logic [9:0]  rd0_pd;
    logic [9:0]  rd1_pd;
    logic [9:0]  wr0_pd;
    logic [0:31] wr0_dat_q;
    logic        rd0_en;
    logic        rd1_en;
`ifdef REGFILE_CTL_BYPASS_EN
    logic        rd0_byp;
    logic        rd1_byp;
`endif

    // Stage B
    logic        rd0_vld_q;
    logic        rd1_vld_q;
    logic [0:31] rd0_dat_q;
    logic [0:31] rd1_dat_q;

    logic        rd0_acc;
    logic        rd1_acc;
    logic        wr_en;
    logic [0:4]  wr_adr;
    logic [0:31] wr_dat;

    function automatic logic [9:0] predecode(input logic en, input logic [0:4] adr);
        logic [9:0] p;
        p[9] = en & ~adr[0];
        p[8] = en &  adr[0];
        p[7] = en & ~adr[1] & ~adr[2];
        p[6] = en & ~adr[1] &  adr[2];
        p[5] = en &  adr[1] & ~adr[2];
        p[4] = en &  adr[1] &  adr[2];
        p[3] = en & ~adr[3];
        p[2] = en &  adr[3];
        p[1] = en & ~adr[4];
        p[0] = en &  adr[4];
        return p;
    endfunction

    assign rd0_acc = (state == RUN) & bus.rd0_req;
    assign rd1_acc = (state == RUN) & bus.rd1_req;

    // The clear sequence borrows the write port while in INIT.
    always_comb begin
        wr_en  = 1'b1;
        wr_adr = cnt;
        wr_dat = '0;
        if (state == RUN) begin
            wr_en  = bus.wr0_req;
            wr_adr = bus.wr0_adr_i;
            wr_dat = bus.wr0_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            ready_q   <= 1'b0;
            rd0_pd    <= '0;
            rd1_pd    <= '0;
            wr0_pd    <= '0;
            wr0_dat_q <= '0;
            rd0_en    <= 1'b0;
            rd1_en    <= 1'b0;
`ifdef REGFILE_CTL_BYPASS_EN
            rd0_byp   <= 1'b0;
            rd1_byp   <= 1'b0;
`endif
            rd0_vld_q <= 1'b0;
            rd1_vld_q <= 1'b0;
            rd0_dat_q <= '0;
            rd1_dat_q <= '0;
        end else begin
            rd0_vld_q <= rd0_en;
            rd1_vld_q <= rd1_en;
`ifdef REGFILE_CTL_BYPASS_EN
            // wr0_dat_q still holds the data of the write accepted with this read.
            if (rd0_en) rd0_dat_q <= rd0_byp ? wr0_dat_q : rd0_dat;
            if (rd1_en) rd1_dat_q <= rd1_byp ? wr0_dat_q : rd1_dat;
            rd0_byp <= rd0_acc & wr_en & (bus.rd0_adr_i == wr_adr);
            rd1_byp <= rd1_acc & wr_en & (bus.rd1_adr_i == wr_adr);
`else
            if (rd0_en) rd0_dat_q <= rd0_dat;
            if (rd1_en) rd1_dat_q <= rd1_dat;
`endif

            rd0_en <= rd0_acc;
            rd1_en <= rd1_acc;
            rd0_pd <= predecode(rd0_acc, bus.rd0_adr_i);
            rd1_pd <= predecode(rd1_acc, bus.rd1_adr_i);
            wr0_pd <= predecode(wr_en, wr_adr);
            if (wr_en) wr0_dat_q <= wr_dat;

            case (state)
                INIT: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.rd0_vld   = rd0_vld_q;
    assign bus.rd1_vld   = rd1_vld_q;
    assign bus.rd0_dat_o = rd0_dat_q;
    assign bus.rd1_dat_o = rd1_dat_q;
    assign wr0_dat       = wr0_dat_q;

    assign {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
            rd0_na3, rd0_a3, rd0_na4, rd0_a4} = rd0_pd;
    assign {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
            rd1_na3, rd1_a3, rd1_na4, rd1_a4} = rd1_pd;
    assign {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
            wr0_na3, wr0_a3, wr0_na4, wr0_a4} = wr0_pd;

endmodule
